// File: rtl/calc_bank_pkg.sv
// Shared types and constants for the calculator operand bank.
package calc_bank_pkg;

    // Keypad command codes; code 7 is reserved and behaves like NOP.
    typedef enum logic [2:0] {
        NOP         = 3'd0,
        DIGIT       = 3'd1,
        BACKSPACE   = 3'd2,
        CLR_ENTRY   = 3'd3,
        CLR_ALL     = 3'd4,
        SET_OP      = 3'd5,
        LOAD_RESULT = 3'd6,
        RESERVED    = 3'd7
    } cmd_e;

    // Command sequencer: accept in IDLE, apply in EXEC.
    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_e;

    // Largest legal decimal digit on dataIn.
    localparam logic [3:0] DIGIT_MAX = 4'd9;

endpackage

// File: rtl/calc_dec_accum.sv
// Decimal accumulator step: value*10+digit and value/10, with overflow flag.
module calc_dec_accum #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] value,
    input  logic [3:0]       digit,
    output logic [WIDTH-1:0] timesTenPlus,
    output logic [WIDTH-1:0] divTen,
    output logic             ovf
);

    // Four guard bits hold value*10+9 exactly, so any set guard bit means overflow.
    logic [WIDTH+3:0] wide;

    // Pure combinational shift-in / shift-out of one decimal digit.
    always_comb begin
        wide         = ({4'b0000, value} * (WIDTH+4)'(10)) + {{WIDTH{1'b0}}, digit};
        timesTenPlus = wide[WIDTH-1:0];
        divTen       = value / WIDTH'(10);
        ovf          = |wide[WIDTH+3:WIDTH];
    end

endmodule

// File: rtl/calc_operand_bank.sv
// Operand store for the calculator: builds decimal operands from keypad
// commands, holds the operator and a captured ALU result, drives the display.
//
// Handshake: a command transfers on a rising edge where cmdValid and cmdReady
// are both high. cmdReady is high only in IDLE, so after each transfer it drops
// for exactly one cycle (EXEC) while the command is applied; the effect is
// visible after that second edge. Upstream may hold cmdValid, in which case a
// new command is taken every second cycle.
module calc_operand_bank
    import calc_bank_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int NUM_OPERANDS = 2,
    parameter int OP_WIDTH     = 4,
    parameter int MAX_DIGITS   = 5,
    localparam int LOC_W       = $clog2(NUM_OPERANDS),
    localparam int DISP_W      = $clog2(NUM_OPERANDS + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cmdValid,
    output logic                          cmdReady,
    input  logic [2:0]                    cmd,
    input  logic [3:0]                    dataIn,
    input  logic [LOC_W-1:0]              memLoc,
    input  logic [DISP_W-1:0]             memDisplay,
    input  logic [WIDTH-1:0]              result,
    input  logic                          resultValid,
    output logic [NUM_OPERANDS*WIDTH-1:0] operands,
    output logic [OP_WIDTH-1:0]           dataOp,
    output logic [WIDTH-1:0]              dataOut,
    output logic [NUM_OPERANDS-1:0]       overflow,
    output logic                          digitErr
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    state_e               state;
    state_e               stateNext;
    cmd_e                 cmdQ;
    logic [3:0]           dataQ;
    logic [LOC_W-1:0]     locQ;
    logic [WIDTH-1:0]     slot  [NUM_OPERANDS];
    logic [CNT_W-1:0]     count [NUM_OPERANDS];
    logic [WIDTH-1:0]     resultReg;
    logic                 exec;
    logic                 locValid;
    logic [WIDTH-1:0]     selVal;
    logic [CNT_W-1:0]     selCnt;
    logic [WIDTH-1:0]     accMul;
    logic [WIDTH-1:0]     accDiv;
    logic                 accOvf;

    assign exec = (state == EXEC);

    // Next-state and ready: accept in IDLE, always spend one EXEC cycle.
    always_comb begin
        stateNext = state;
        cmdReady  = 1'b0;
        case (state)
            IDLE: begin
                cmdReady = 1'b1;
                if (cmdValid) stateNext = EXEC;
            end
            EXEC: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    // Latch the command fields on the handshake edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmdQ  <= NOP;
            dataQ <= 4'd0;
            locQ  <= '0;
        end else if (cmdValid && cmdReady) begin
            cmdQ  <= cmd_e'(cmd);
            dataQ <= dataIn;
            locQ  <= memLoc;
        end
    end

    // Select the addressed slot; out-of-range locations read as empty and are ignored.
    always_comb begin
        locValid = (int'(locQ) < NUM_OPERANDS);
        selVal   = '0;
        selCnt   = '0;
        if (locValid) begin
            selVal = slot[locQ];
            selCnt = count[locQ];
        end
    end

    calc_dec_accum #(.WIDTH(WIDTH)) uAccum (
        .value        (selVal),
        .digit        (dataQ),
        .timesTenPlus (accMul),
        .divTen       (accDiv),
        .ovf          (accOvf)
    );

    // Apply the latched command to slots, counts, overflow flags and operator.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_OPERANDS; i++) begin
                slot[i]  <= '0;
                count[i] <= '0;
            end
            overflow <= '0;
            dataOp   <= '0;
            digitErr <= 1'b0;
        end else begin
            digitErr <= 1'b0;
            if (exec) begin
                case (cmdQ)
                    DIGIT: if (locValid) begin
                        if (dataQ > DIGIT_MAX) begin
                            digitErr <= 1'b1;
                        end else if (selCnt == CNT_W'(MAX_DIGITS) || accOvf) begin
                            overflow[locQ] <= 1'b1;
                        end else begin
                            slot[locQ] <= accMul;
                            // A leading zero does not consume a digit position.
                            if (!(selCnt == '0 && dataQ == 4'd0)) count[locQ] <= selCnt + CNT_W'(1);
                        end
                    end
                    BACKSPACE: if (locValid) begin
                        slot[locQ]     <= accDiv;
                        overflow[locQ] <= 1'b0;
                        if (selCnt != '0) count[locQ] <= selCnt - CNT_W'(1);
                    end
                    CLR_ENTRY: if (locValid) begin
                        slot[locQ]     <= '0;
                        count[locQ]    <= '0;
                        overflow[locQ] <= 1'b0;
                    end
                    CLR_ALL: begin
                        for (int i = 0; i < NUM_OPERANDS; i++) begin
                            slot[i]  <= '0;
                            count[i] <= '0;
                        end
                        overflow <= '0;
                        dataOp   <= '0;
                    end
                    SET_OP: dataOp <= dataQ[OP_WIDTH-1:0];
                    LOAD_RESULT: begin
                        // Chained result counts as a full entry so further digits overflow.
                        for (int i = 0; i < NUM_OPERANDS; i++) begin
                            slot[i]  <= (i == 0) ? resultReg : '0;
                            count[i] <= (i == 0) ? CNT_W'(MAX_DIGITS) : '0;
                        end
                        overflow <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Result capture; an executing CLR_ALL takes priority over a same-edge strobe.
    always_ff @(posedge clk) begin
        if (reset)                          resultReg <= '0;
        else if (exec && cmdQ == CLR_ALL)   resultReg <= '0;
        else if (resultValid)               resultReg <= result;
    end

    // Registered display mux: slots, then the result register, else blank.
    always_ff @(posedge clk) begin
        if (reset)                                     dataOut <= '0;
        else if (int'(memDisplay) < NUM_OPERANDS)      dataOut <= slot[memDisplay[LOC_W-1:0]];
        else if (int'(memDisplay) == NUM_OPERANDS)     dataOut <= resultReg;
        else                                           dataOut <= '0;
    end

    // Flatten slots onto the operand bus, slot 0 in the LSBs.
    always_comb begin
        for (int i = 0; i < NUM_OPERANDS; i++) operands[i*WIDTH +: WIDTH] = slot[i];
    end

endmodule

// File: tb/tb_calc_operand_bank.sv
// Directed bench for calc_operand_bank: commands push an expected snapshot,
// a monitor compares it when the bank returns to ready.
module tb_calc_operand_bank;
    import calc_bank_pkg::*;

    localparam int WIDTH = 16;
    localparam int SW    = 39;  // {slot1, slot0, overflow, dataOp, digitErr}

    logic         clk = 1'b0;
    logic         reset;
    logic         cmdValid;
    logic         cmdReady;
    logic [2:0]   cmd;
    logic [3:0]   dataIn;
    logic [0:0]   memLoc;
    logic [1:0]   memDisplay;
    logic [15:0]  result;
    logic         resultValid;
    logic [31:0]  operands;
    logic [3:0]   dataOp;
    logic [15:0]  dataOut;
    logic [1:0]   overflow;
    logic         digitErr;

    logic [SW-1:0] expQ[$];
    int nCompared = 0;
    int nMismatch = 0;
    logic prevReady = 1'b1;

    // Clock.
    always #5 clk = ~clk;

    calc_operand_bank #(.WIDTH(WIDTH), .NUM_OPERANDS(2), .OP_WIDTH(4), .MAX_DIGITS(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmdValid    (cmdValid),
        .cmdReady    (cmdReady),
        .cmd         (cmd),
        .dataIn      (dataIn),
        .memLoc      (memLoc),
        .memDisplay  (memDisplay),
        .result      (result),
        .resultValid (resultValid),
        .operands    (operands),
        .dataOp      (dataOp),
        .dataOut     (dataOut),
        .overflow    (overflow),
        .digitErr    (digitErr)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [SW-1:0] snap(input logic [15:0] s0, input logic [15:0] s1,
                                           input logic [1:0] ov, input logic [3:0] op,
                                           input logic err);
        return {s1, s0, ov, op, err};
    endfunction

    // Monitor: a ready rising edge marks a completed command.
    always @(posedge clk) begin
        #2;
        if (reset) begin
            prevReady = cmdReady;
        end else begin
            if (!prevReady && cmdReady) begin
                if (expQ.size() == 0) begin
                    nCompared++;
                    nMismatch++;
                    $display("FAIL unexpectedDone: completion with empty queue at %0t", $time);
                end else begin
                    check("cmdDone", 64'({operands, overflow, dataOp, digitErr}), 64'(expQ.pop_front()));
                end
            end
            prevReady = cmdReady;
        end
    end

    // Driver: one command, optional result strobe on the execute edge.
    task automatic issue(input cmd_e c, input logic [3:0] d, input logic l,
                         input logic [SW-1:0] exp, input logic rvAtExec, input logic [15:0] rv);
        int waitCnt = 0;
        @(negedge clk);
        while (!cmdReady && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!cmdReady) begin
            nCompared++;
            nMismatch++;
            $display("FAIL readyTimeout: cmdReady stuck low at %0t", $time);
        end
        cmd = c; dataIn = d; memLoc = l; cmdValid = 1'b1;
        expQ.push_back(exp);
        @(negedge clk);
        cmdValid = 1'b0;
        check("readyLow", 64'(cmdReady), 64'(0));
        if (rvAtExec) begin
            resultValid = 1'b1;
            result = rv;
        end
        @(negedge clk);
        resultValid = 1'b0;
        check("readyBack", 64'(cmdReady), 64'(1));
    endtask

    task automatic strobeResult(input logic [15:0] rv);
        @(negedge clk);
        result = rv; resultValid = 1'b1;
        @(negedge clk);
        resultValid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cmdValid = 1'b0; cmd = 3'd0; dataIn = 4'd0; memLoc = 1'b0;
        memDisplay = 2'd0; result = 16'h1234; resultValid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("resetSnap", 64'({operands, overflow, dataOp, digitErr}), 64'(snap(0, 0, 0, 0, 0)));
        check("resetReady", 64'(cmdReady), 64'(1));
        check("resetDataOut", 64'(dataOut), 64'(0));

        // Slot 0: 1, 2, 3 -> 123.
        issue(DIGIT, 4'd1, 1'b0, snap(1, 0, 0, 0, 0), 1'b0, 16'd0);
        issue(DIGIT, 4'd2, 1'b0, snap(12, 0, 0, 0, 0), 1'b0, 16'd0);
        issue(DIGIT, 4'd3, 1'b0, snap(123, 0, 0, 0, 0), 1'b0, 16'd0);
        @(negedge clk);
        check("dataOut123", 64'(dataOut), 64'(123));
        check("operands0", 64'(operands[15:0]), 64'(123));

        // Slot 1: 65535 then a sixth digit hits the count limit.
        issue(DIGIT, 4'd6, 1'b1, snap(123, 6, 0, 0, 0), 1'b0, 16'd0);
        issue(DIGIT, 4'd5, 1'b1, snap(123, 65, 0, 0, 0), 1'b0, 16'd0);
        issue(DIGIT, 4'd5, 1'b1, snap(123, 655, 0, 0, 0), 1'b0, 16'd0);
        issue(DIGIT, 4'd3, 1'b1, snap(123, 6553, 0, 0, 0), 1'b0, 16'd0);
        issue(DIGIT, 4'd5, 1'b1, snap(123, 65535, 0, 0, 0), 1'b0, 16'd0);
        issue(DIGIT, 4'd6, 1'b1, snap(123, 65535, 2'b10, 0, 0), 1'b0, 16'd0);
        issue(BACKSPACE, 4'd0, 1'b1, snap(123, 6553, 2'b00, 0, 0), 1'b0, 16'd0);
        // Four digits, but 65536 exceeds the width.
        issue(DIGIT, 4'd6, 1'b1, snap(123, 6553, 2'b10, 0, 0), 1'b0, 16'd0);
        issue(CLR_ENTRY, 4'd0, 1'b1, snap(123, 0, 2'b00, 0, 0), 1'b0, 16'd0);
        issue(DIGIT, 4'd0, 1'b1, snap(123, 0, 0, 0, 0), 1'b0, 16'd0);
        issue(DIGIT, 4'd7, 1'b1, snap(123, 7, 0, 0, 0), 1'b0, 16'd0);
        memDisplay = 2'd1;
        @(negedge clk);
        check("dataOutSlot1", 64'(dataOut), 64'(7));

        // Illegal digit and operator.
        issue(DIGIT, 4'd12, 1'b0, snap(123, 7, 0, 0, 1), 1'b0, 16'd0);
        @(negedge clk);
        check("errOneCycle", 64'(digitErr), 64'(0));
        issue(SET_OP, 4'hA, 1'b0, snap(123, 7, 0, 4'hA, 0), 1'b0, 16'd0);

        // Result capture, display and chaining.
        strobeResult(16'd42);
        memDisplay = 2'd2;
        @(negedge clk);
        check("dataOutResult", 64'(dataOut), 64'(42));
        issue(LOAD_RESULT, 4'd0, 1'b0, snap(42, 0, 0, 4'hA, 0), 1'b0, 16'd0);
        issue(DIGIT, 4'd1, 1'b0, snap(42, 0, 2'b01, 4'hA, 0), 1'b0, 16'd0);
        issue(NOP, 4'd3, 1'b0, snap(42, 0, 2'b01, 4'hA, 0), 1'b0, 16'd0);
        issue(RESERVED, 4'd3, 1'b1, snap(42, 0, 2'b01, 4'hA, 0), 1'b0, 16'd0);

        // LOAD_RESULT takes the old register value when a strobe lands on the same edge.
        strobeResult(16'd7);
        issue(LOAD_RESULT, 4'd0, 1'b0, snap(7, 0, 0, 4'hA, 0), 1'b1, 16'd8);
        @(negedge clk);
        check("dataOutNewResult", 64'(dataOut), 64'(8));
        memDisplay = 2'd3;
        @(negedge clk);
        check("dataOutBlank", 64'(dataOut), 64'(0));
        issue(BACKSPACE, 4'd0, 1'b0, snap(0, 0, 0, 4'hA, 0), 1'b0, 16'd0);
        issue(DIGIT, 4'd9, 1'b1, snap(0, 9, 0, 4'hA, 0), 1'b0, 16'd0);

        // CLR_ALL beats a same-edge result strobe.
        memDisplay = 2'd2;
        issue(CLR_ALL, 4'd0, 1'b0, snap(0, 0, 0, 0, 0), 1'b1, 16'd99);
        @(negedge clk);
        check("clrAllResult", 64'(dataOut), 64'(0));

        // Reset during EXEC discards the pending command.
        @(negedge clk);
        cmd = DIGIT; dataIn = 4'd7; memLoc = 1'b0; cmdValid = 1'b1;
        @(negedge clk);
        cmdValid = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("resetDiscard", 64'(operands), 64'(0));
        @(negedge clk);
        check("readyAfterReset", 64'(cmdReady), 64'(1));
        check("resetDiscardLater", 64'(operands), 64'(0));
        issue(DIGIT, 4'd4, 1'b0, snap(4, 0, 0, 0, 0), 1'b0, 16'd0);

        repeat (3) @(negedge clk);
        check("queueEmpty", 64'(expQ.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
